// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: state encodings, data width and the
//                even-parity helper used by the RX deserializer and TX side.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deser_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deser_if
//  Description : Pin-side and byte-side signals of the UART receiver.
//                UART_RX_PARITY_EN adds the parity-error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_deser_if;

    logic                           uart_rx;
    logic                           uart_rx_byte_valid;
    logic [uart_pkg::DATA_BITS-1:0] uart_rx_byte;
    logic                           uart_rx_frame_error;
    logic                           uart_rx_busy;
`ifdef UART_RX_PARITY_EN
    logic                           uart_rx_parity_error;
`endif

    // master: the receiver itself; slave: pin driver and byte consumer
    modport master (
`ifdef UART_RX_PARITY_EN
        output uart_rx_parity_error,
`endif
        input  uart_rx,
        output uart_rx_byte_valid,
        output uart_rx_byte,
        output uart_rx_frame_error,
        output uart_rx_busy
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  uart_rx_parity_error,
`endif
        output uart_rx,
        input  uart_rx_byte_valid,
        input  uart_rx_byte,
        input  uart_rx_frame_error,
        input  uart_rx_busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_deser_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-flop synchronizer for an asynchronous input; resets to 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_deser
//  Description : Oversampling UART receiver (8N1) producing byte strobes.
//                Define UART_RX_PARITY_EN for an even-parity bit and strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 27,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    uart_rx_deser_if.master  rx_bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4 || SYNC_STAGES < 2) begin : g_param_check
            $error("uart_rx_deser: CLKS_PER_BIT must be >= 4 and SYNC_STAGES >= 2");
        end
    endgenerate

    logic                  w_rx_s;
    logic                  w_tick;
    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_byte;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_busy;
`ifdef UART_RX_PARITY_EN
    logic                  r_perr;
    logic                  r_par_bit;
`endif

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_bus.uart_rx),
        .o_q   (w_rx_s)
    );

    assign w_tick = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                // Re-check the line at mid start bit so short glitches are dropped
                START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) begin
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) begin
                        r_par_bit <= w_rx_s;
                        r_state   <= STOP;
                    end
                end
`endif
                // Leave at the stop midpoint so a following start edge is caught
                STOP: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) begin
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (even_parity(r_shift) != r_par_bit) begin
                                r_perr <= 1'b1;
                            end else begin
                                r_valid <= 1'b1;
                                r_byte  <= r_shift;
                            end
`else
                            r_valid <= 1'b1;
                            r_byte  <= r_shift;
`endif
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_bus.uart_rx_byte_valid  = r_valid;
    assign rx_bus.uart_rx_byte        = r_byte;
    assign rx_bus.uart_rx_frame_error = r_ferr;
    assign rx_bus.uart_rx_busy        = r_busy;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.uart_rx_parity_error = r_perr;
`endif

endmodule
`default_nettype wire
